// File: rtl/countdown_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
// State encoding is visible on the state output.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    RUN   = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam logic [3:0] UNIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  function automatic logic [3:0] clamp(
    input logic [3:0] d,
    input logic [3:0] mx
  );
    return (d > mx) ? mx : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with borrow chain.
// Wraps 0 -> MAX when a borrow arrives.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter logic [3:0] MAX = UNIT_MAX
) (
  input  logic       fclk,
  input  logic       reset,
  input  logic       en,
  input  logic       bin,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       bout
);

  always_ff @(posedge fclk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= clamp(d, MAX);
    end else if (en && bin) begin
      q <= (q == 4'd0) ? MAX : q - 4'd1;
    end
  end

  assign bout = bin & (q == 4'd0);

endmodule

// File: rtl/countdown_timer_mmss.sv
// mm:ss BCD countdown timer with done pulse and
// tick-counted alarm hold.
module countdown_timer_mmss
  import countdown_pkg::*;
#(
  parameter int ALARM_TICKS = 10
) (
  input  logic       fclk,
  input  logic       reset,
  input  logic       tick,
  input  logic       control,
  input  logic       load,
  input  logic [2:0] pre_min_t,
  input  logic [3:0] pre_min_u,
  input  logic [2:0] pre_sec_t,
  input  logic [3:0] pre_sec_u,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic       sec_bw,
  output logic       done,
  output logic       alarm,
  output logic [1:0] state
);

  localparam logic [3:0] ACNT = 4'(ALARM_TICKS);

  state_t     st, st_n;
  logic [3:0] cnt, cnt_n;
  logic       done_n, bw_n, alarm_n;
  logic       dec;
  logic       bo_su, bo_st, bo_mu, bo_mt;
  logic       is_one, nz;

  bcd_down_digit #(.MAX(UNIT_MAX)) u_su (
    .fclk(fclk), .reset(reset), .en(dec),
    .bin(1'b1), .load(load), .d(pre_sec_u),
    .q(sec_u), .bout(bo_su)
  );

  bcd_down_digit #(.MAX(TENS_MAX)) u_st (
    .fclk(fclk), .reset(reset), .en(dec),
    .bin(bo_su), .load(load),
    .d({1'b0, pre_sec_t}),
    .q(sec_t), .bout(bo_st)
  );

  bcd_down_digit #(.MAX(UNIT_MAX)) u_mu (
    .fclk(fclk), .reset(reset), .en(dec),
    .bin(bo_st), .load(load), .d(pre_min_u),
    .q(min_u), .bout(bo_mu)
  );

  bcd_down_digit #(.MAX(TENS_MAX)) u_mt (
    .fclk(fclk), .reset(reset), .en(dec),
    .bin(bo_mu), .load(load),
    .d({1'b0, pre_min_t}),
    .q(min_t), .bout(bo_mt)
  );

  // Clamping never changes zero-ness, so test the raw preset.
  assign nz = |{pre_min_t, pre_min_u,
                pre_sec_t, pre_sec_u};

  assign is_one = (min_t == 4'd0) && (min_u == 4'd0)
               && (sec_t == 4'd0) && (sec_u == 4'd1);

  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    done_n  = 1'b0;
    bw_n    = 1'b0;
    alarm_n = alarm;
    dec     = 1'b0;
    if (load) begin
      alarm_n = 1'b0;
      cnt_n   = '0;
      st_n    = nz ? HOLD : IDLE;
    end else begin
      unique case (st)
        IDLE: begin
        end
        HOLD: begin
          if (!control) st_n = RUN;
        end
        RUN: begin
          if (control) begin
            st_n = HOLD;
          end else if (tick && !bo_mt) begin
            dec  = 1'b1;
            bw_n = bo_st;
            if (is_one) begin
              st_n    = ALARM;
              cnt_n   = ACNT;
              done_n  = 1'b1;
              alarm_n = 1'b1;
            end
          end
        end
        ALARM: begin
          if (tick) begin
            cnt_n = cnt - 4'd1;
            if (cnt == 4'd1) begin
              alarm_n = 1'b0;
              st_n    = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge fclk or negedge reset) begin
    if (!reset) begin
      st     <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      sec_bw <= 1'b0;
      alarm  <= 1'b0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      done   <= done_n;
      sec_bw <= bw_n;
      alarm  <= alarm_n;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Directed bench for countdown_timer_mmss with a
// seconds-count reference model checked every cycle.
module tb_countdown_timer_mmss;

  localparam int AT = 10;

  logic       fclk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       control = 1'b1;
  logic       load = 1'b0;
  logic [2:0] pre_min_t = '0;
  logic [3:0] pre_min_u = '0;
  logic [2:0] pre_sec_t = '0;
  logic [3:0] pre_sec_u = '0;
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic       sec_bw, done, alarm;
  logic [1:0] state;

  int n_chk = 0;
  int n_fail = 0;

  countdown_timer_mmss #(.ALARM_TICKS(AT)) dut (
    .fclk(fclk), .reset(reset), .tick(tick),
    .control(control), .load(load),
    .pre_min_t(pre_min_t), .pre_min_u(pre_min_u),
    .pre_sec_t(pre_sec_t), .pre_sec_u(pre_sec_u),
    .min_t(min_t), .min_u(min_u),
    .sec_t(sec_t), .sec_u(sec_u),
    .sec_bw(sec_bw), .done(done),
    .alarm(alarm), .state(state)
  );

  always #5 fclk = ~fclk;

  // Model: total seconds remaining plus a state number.
  int m_secs, m_st, m_acnt;
  bit m_done, m_bw, m_alarm;

  function automatic int cl(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge fclk or negedge reset) begin
    if (!reset) begin
      m_secs = 0; m_st = 0; m_acnt = 0;
      m_done = 0; m_bw = 0; m_alarm = 0;
    end else begin
      m_done = 0;
      m_bw = 0;
      if (load) begin
        m_secs = cl(int'(pre_min_t), 5) * 600
               + cl(int'(pre_min_u), 9) * 60
               + cl(int'(pre_sec_t), 5) * 10
               + cl(int'(pre_sec_u), 9);
        m_alarm = 0;
        m_acnt = 0;
        m_st = (m_secs != 0) ? 1 : 0;
      end else if (m_st == 1) begin
        if (!control) m_st = 2;
      end else if (m_st == 2) begin
        if (control) m_st = 1;
        else if (tick) begin
          if (m_secs % 60 == 0) m_bw = 1;
          m_secs = m_secs - 1;
          if (m_secs == 0) begin
            m_done = 1; m_alarm = 1;
            m_st = 3; m_acnt = AT;
          end
        end
      end else if (m_st == 3) begin
        if (tick) begin
          m_acnt = m_acnt - 1;
          if (m_acnt == 0) begin
            m_alarm = 0; m_st = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, got, exp, $time);
    end
  endtask

  always @(negedge fclk) begin
    chk("min_t", 32'(min_t), m_secs / 600);
    chk("min_u", 32'(min_u), (m_secs / 60) % 10);
    chk("sec_t", 32'(sec_t), (m_secs % 60) / 10);
    chk("sec_u", 32'(sec_u), m_secs % 10);
    chk("sec_bw", 32'(sec_bw), 32'(m_bw));
    chk("done", 32'(done), 32'(m_done));
    chk("alarm", 32'(alarm), 32'(m_alarm));
    chk("state", 32'(state), m_st);
  end

  task automatic cyc(input bit t, input bit l);
    tick = t;
    load = l;
    @(posedge fclk);
    #1;
    tick = 1'b0;
    load = 1'b0;
  endtask

  task automatic setp(input int mt, input int mu,
                      input int st, input int su);
    pre_min_t = 3'(mt);
    pre_min_u = 4'(mu);
    pre_sec_t = 3'(st);
    pre_sec_u = 4'(su);
  endtask

  task automatic lit(input string nm, input int a,
                     input int b, input int c,
                     input int d);
    chk({nm, ".mt"}, 32'(min_t), a);
    chk({nm, ".mu"}, 32'(min_u), b);
    chk({nm, ".st"}, 32'(sec_t), c);
    chk({nm, ".su"}, 32'(sec_u), d);
  endtask

  initial begin
    repeat (2) @(posedge fclk);
    #1;
    lit("rst", 0, 0, 0, 0);
    chk("rst_state", 32'(state), 0);
    reset = 1'b1;

    // 01:00 -> 00:59 with seconds borrow
    control = 1'b1;
    setp(0, 1, 0, 0);
    cyc(0, 1);
    chk("t1_hold", 32'(state), 1);
    control = 1'b0;
    cyc(0, 0);
    chk("t1_run", 32'(state), 2);
    cyc(1, 0);
    lit("t1", 0, 0, 5, 9);
    chk("t1_bw", 32'(sec_bw), 1);
    chk("t1_msecs", m_secs, 59);
    cyc(0, 0);
    chk("t1_bw_off", 32'(sec_bw), 0);

    // 00:02 -> done -> alarm for AT ticks
    control = 1'b1;
    setp(0, 0, 0, 2);
    cyc(0, 1);
    control = 1'b0;
    cyc(0, 0);
    cyc(1, 0);
    lit("t2a", 0, 0, 0, 1);
    cyc(1, 0);
    lit("t2b", 0, 0, 0, 0);
    chk("t2_done", 32'(done), 1);
    chk("t2_alarm", 32'(alarm), 1);
    chk("t2_state", 32'(state), 3);
    cyc(0, 0);
    chk("t2_done_off", 32'(done), 0);
    control = 1'b1;
    for (int i = 0; i < AT - 1; i++) begin
      cyc(1, 0);
      cyc(0, 0);
    end
    chk("t2_alarm_hold", 32'(alarm), 1);
    chk("t2_state_hold", 32'(state), 3);
    cyc(1, 0);
    chk("t2_alarm_end", 32'(alarm), 0);
    chk("t2_idle", 32'(state), 0);

    // 00:00 preset stays idle
    setp(0, 0, 0, 0);
    cyc(0, 1);
    chk("t3_state", 32'(state), 0);
    control = 1'b0;
    repeat (3) cyc(1, 0);
    lit("t3", 0, 0, 0, 0);
    chk("t3_done", 32'(done), 0);

    // 10:00 -> 09:59, hold drops coincident tick
    control = 1'b1;
    setp(1, 0, 0, 0);
    cyc(0, 1);
    control = 1'b0;
    cyc(0, 0);
    cyc(1, 0);
    lit("t4", 0, 9, 5, 9);
    control = 1'b1;
    cyc(1, 0);
    lit("t4h", 0, 9, 5, 9);
    chk("t4_hold", 32'(state), 1);

    // raw 7:F:7:F clamps, reset mid-run
    setp(7, 15, 7, 15);
    cyc(0, 1);
    lit("t5", 5, 9, 5, 9);
    chk("t5_msecs", m_secs, 3599);
    control = 1'b0;
    cyc(0, 0);
    repeat (3) cyc(1, 0);
    lit("t5r", 5, 9, 5, 6);
    reset = 1'b0;
    #2;
    lit("t5z", 0, 0, 0, 0);
    chk("t5_state", 32'(state), 0);
    chk("t5_alarm", 32'(alarm), 0);
    @(posedge fclk);
    #1;
    reset = 1'b1;
    cyc(1, 0);
    chk("t5_idle", 32'(state), 0);

    // held load freezes count; load beats tick
    setp(0, 0, 0, 5);
    cyc(1, 1);
    cyc(1, 1);
    lit("t6l", 0, 0, 0, 5);
    cyc(0, 0);
    cyc(1, 0);
    cyc(1, 0);
    lit("t6a", 0, 0, 0, 3);
    setp(0, 3, 0, 0);
    cyc(1, 1);
    lit("t6b", 0, 3, 0, 0);
    chk("t6_state", 32'(state), 1);
    chk("t6_bw", 32'(sec_bw), 0);
    cyc(0, 0);
    cyc(1, 0);
    lit("t6c", 0, 2, 5, 9);

    @(negedge fclk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
